// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache.
//   cache_state_e : controller states. The encodings are also exported as
//                   localparam constants so that older code can keep using them.
//   idx_w/tag_w/way_w : derive the address-field and way-select widths from the
//                   cache geometry.
//   line_meta_t   : per-line valid/dirty bits.
package cache_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_WRITEBACK = 3'd2;
  localparam logic [2:0] ST_REFILL    = 3'd3;
  localparam logic [2:0] ST_RESPOND   = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LOOKUP    = ST_LOOKUP,
    WRITEBACK = ST_WRITEBACK,
    REFILL    = ST_REFILL,
    RESPOND   = ST_RESPOND
  } cache_state_e;

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Two low address bits select a byte within the word and are not stored.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
    return addr_w - $clog2(sets) - 2;
  endfunction

  function automatic int unsigned way_w(input int unsigned ways);
    return $clog2(ways);
  endfunction

  typedef struct packed {
    logic valid;
    logic dirty;
  } line_meta_t;

endpackage

// File: rtl/cache_lru.sv
// Age-based LRU tracker, one age per way per set.
//   clk, reset : clock, synchronous active-high reset (ages reset to age[w]=w)
//   set_i      : set being looked up / touched
//   touch_i    : mark way_i of set_i as most recently used this cycle
//   way_i      : way to touch
//   victim_o   : way of set_i holding the oldest age (WAYS-1)
module cache_lru
  import cache_pkg::*;
#(
  parameter int unsigned SETS = 16,
  parameter int unsigned WAYS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [idx_w(SETS)-1:0]   set_i,
  input  logic                     touch_i,
  input  logic [way_w(WAYS)-1:0]   way_i,
  output logic [way_w(WAYS)-1:0]   victim_o
);

  localparam int unsigned WAY_W = way_w(WAYS);

  logic [WAY_W-1:0] age_q [SETS][WAYS];

  // Touched way becomes age 0; ways younger than its old age shift up by one,
  // which keeps each set's ages a permutation of 0..WAYS-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (touch_i) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == way_i)
          age_q[set_i][w] <= '0;
        else if (age_q[set_i][w] < age_q[set_i][way_i])
          age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int unsigned w = 0; w < WAYS; w++)
      if (age_q[set_i][w] == WAY_W'(WAYS - 1))
        victim_o = WAY_W'(w);
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back, write-allocate cache, one word per line.
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready, rd_wr,
//   address, write_data             : CPU request (req_ready only in IDLE)
//   resp_valid, read_data, hit_miss : one-cycle response pulse
//   mem_req_valid/mem_req_ready,
//   mem_we, mem_addr, mem_wdata     : next-level request (writeback or refill read)
//   mem_rvalid, mem_rdata           : refill data return
// Optional build macro CACHE_STATS_EN adds saturating hit_cnt/miss_cnt/wb_cnt outputs.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rd_wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              hit_miss,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
`endif
);

  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, SETS);
  localparam int unsigned WAY_W = way_w(WAYS);

  cache_state_e      state_q, state_d;
  logic              rd_wr_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              hit_q, sent_q;
  logic [WAY_W-1:0]  way_q;

  logic [TAG_W-1:0]  tags_q [SETS][WAYS];
  logic [DATA_W-1:0] data_q [SETS][WAYS];
  line_meta_t        meta_q [SETS][WAYS];

  logic              hit, inv_found, victim_dirty;
  logic [WAY_W-1:0]  hit_way, inv_way, lru_victim, victim;
  logic              wr_en, wr_dirty, touch;
  logic [WAY_W-1:0]  wr_way, touch_way;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        unused_byte_sel;

  assign unused_byte_sel = address[1:0];

  cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk      (clk),
    .reset    (reset),
    .set_i    (idx_q),
    .touch_i  (touch),
    .way_i    (touch_way),
    .victim_o (lru_victim)
  );

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && meta_q[idx_q][w].valid && tags_q[idx_q][w] == tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !meta_q[idx_q][w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim       = inv_found ? inv_way : lru_victim;
    victim_dirty = meta_q[idx_q][victim].valid && meta_q[idx_q][victim].dirty;
  end

  // Every line install (write hit, write miss, refill) goes through wr_en and
  // also touches the LRU; read hits touch without writing.
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    wr_way    = way_q;
    wr_data   = wdata_q;
    wr_dirty  = 1'b1;
    touch     = 1'b0;
    touch_way = hit_way;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          touch   = 1'b1;
          state_d = RESPOND;
          if (rd_wr_q) begin
            wr_en  = 1'b1;
            wr_way = hit_way;
          end
        end else if (victim_dirty) begin
          state_d = WRITEBACK;
        end else if (!rd_wr_q) begin
          state_d = REFILL;
        end else begin
          wr_en   = 1'b1;
          wr_way  = victim;
          state_d = RESPOND;
        end
      end
      WRITEBACK: begin
        if (mem_req_ready) begin
          if (rd_wr_q) begin
            wr_en   = 1'b1;
            state_d = RESPOND;
          end else begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        if (sent_q && mem_rvalid) begin
          wr_en    = 1'b1;
          wr_data  = mem_rdata;
          wr_dirty = 1'b0;
          state_d  = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_en) begin
      touch     = 1'b1;
      touch_way = wr_way;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_wr_q <= 1'b0;
      tag_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      sent_q  <= 1'b0;
      way_q   <= '0;
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          meta_q[s][w] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        rd_wr_q <= rd_wr;
        tag_q   <= address[ADDR_W-1:IDX_W+2];
        idx_q   <= address[IDX_W+1:2];
        wdata_q <= write_data;
      end
      if (state_q == LOOKUP) begin
        hit_q <= hit;
        way_q <= hit ? hit_way : victim;
      end
      // Refill read is issued once; afterwards only mem_rvalid is awaited.
      sent_q <= (state_q == REFILL) && (sent_q || mem_req_ready);
      if (state_q == LOOKUP && hit && !rd_wr_q)
        rdata_q <= data_q[idx_q][hit_way];
      else if (wr_en)
        rdata_q <= wr_data;
      if (wr_en)
        meta_q[idx_q][wr_way] <= '{valid: 1'b1, dirty: wr_dirty};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags_q[idx_q][wr_way] <= tag_q;
      data_q[idx_q][wr_way] <= wr_data;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESPOND);
  assign hit_miss      = resp_valid && hit_q;
  assign read_data     = resp_valid ? rdata_q : '0;
  assign mem_req_valid = (state_q == WRITEBACK) || (state_q == REFILL && !sent_q);
  assign mem_we        = (state_q == WRITEBACK);
  assign mem_addr      = (state_q == WRITEBACK) ? {tags_q[idx_q][way_q], idx_q, 2'b00} :
                         (state_q == REFILL)    ? {tag_q, idx_q, 2'b00} : '0;
  assign mem_wdata     = (state_q == WRITEBACK) ? data_q[idx_q][way_q] : '0;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == RESPOND) begin
        if (hit_q && hit_cnt_q != '1)        hit_cnt_q  <= hit_cnt_q + 1'b1;
        else if (!hit_q && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
      if (state_q == WRITEBACK && mem_req_ready && wb_cnt_q != '1)
        wb_cnt_q <= wb_cnt_q + 1'b1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        reset, req_valid, rd_wr, req_ready, resp_valid, hit_miss;
  logic [31:0] address, write_data, read_data;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  set_assoc_cache #(.ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rd_wr(rd_wr), .address(address), .write_data(write_data),
    .resp_valid(resp_valid), .read_data(read_data), .hit_miss(hit_miss),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } mem_op_t;
  typedef struct packed { logic hit; logic [31:0] data; } resp_t;
  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata;
    logic hit; logic [31:0] data;
    int unsigned nmem; mem_op_t op0; mem_op_t op1;
  } vec_t;

  resp_t       exp_resp_q[$];
  mem_op_t     exp_mem_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0, n_fail = 0;
  int unsigned rd_lat = 1;
  int unsigned tb_hits = 0, tb_misses = 0, tb_wbs = 0;
  vec_t        vecs [15];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  function automatic mem_op_t rop(input logic [31:0] a);
    return '{we: 1'b0, addr: a, data: 32'h0};
  endfunction

  function automatic mem_op_t wop(input logic [31:0] a, input logic [31:0] d);
    return '{we: 1'b1, addr: a, data: d};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic h, input logic [31:0] d, input int unsigned n,
                              input mem_op_t o0, input mem_op_t o1);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.hit = h; v.data = d;
    v.nmem = n; v.op0 = o0; v.op1 = o1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual missing/unexpected event required none", name);
  endtask

  // Memory model, response scoreboard and memory-request scoreboard, all
  // sampled on the falling edge.
  initial begin
    logic        pend;
    int unsigned cnt;
    logic [31:0] paddr;
    resp_t       r;
    mem_op_t     op;
    pend = 1'b0; cnt = 0; paddr = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend) begin
        if (cnt > 0) cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem.exists(paddr) ? mem[paddr] : dflt(paddr);
          pend       = 1'b0;
        end
      end
      if (resp_valid) begin
        if (exp_resp_q.size() == 0) fail_event("resp_unexpected");
        else begin
          r = exp_resp_q.pop_front();
          check("resp_hit", hit_miss, r.hit);
          check("resp_data", read_data, r.data);
          if (r.hit) tb_hits++; else tb_misses++;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem_q.size() == 0) fail_event("mem_unexpected");
        else begin
          op = exp_mem_q.pop_front();
          check("mem_we", mem_we, op.we);
          check("mem_addr", mem_addr, op.addr);
          if (op.we) check("mem_wdata", mem_wdata, op.data);
        end
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          tb_wbs++;
        end else begin
          pend = 1'b1; cnt = rd_lat; paddr = mem_addr;
        end
      end
    end
  end

  task automatic send_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int unsigned k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!req_ready) fail_event("req_ready_timeout");
    rd_wr = wr; address = a; write_data = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, output int unsigned cyc);
    cyc = 0;
    while (exp_resp_q.size() != 0 && cyc < 200) begin @(posedge clk); cyc++; end
    if (exp_resp_q.size() != 0) begin
      fail_event(name);
      exp_resp_q.delete();
    end
    #1;
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check("hit_cnt", hit_cnt, tb_hits);
    check("miss_cnt", miss_cnt, tb_misses);
    check("wb_cnt", wb_cnt, tb_wbs);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc, k;
    vec_t        v;
    vecs[0]  = mk(0, 32'h40,  0, 0, 32'hDEADBEEF, 1, rop(32'h40), rop(0));
    vecs[1]  = mk(0, 32'h40,  0, 1, 32'hDEADBEEF, 0, rop(0), rop(0));
    vecs[2]  = mk(1, 32'h80,  32'h12345678, 0, 32'h12345678, 0, rop(0), rop(0));
    vecs[3]  = mk(0, 32'h80,  0, 1, 32'h12345678, 0, rop(0), rop(0));
    vecs[4]  = mk(0, 32'hC0,  0, 0, dflt(32'hC0), 1, rop(32'hC0), rop(0));
    vecs[5]  = mk(0, 32'h100, 0, 0, dflt(32'h100), 1, rop(32'h100), rop(0));
    vecs[6]  = mk(0, 32'h40,  0, 1, 32'hDEADBEEF, 0, rop(0), rop(0));
    vecs[7]  = mk(0, 32'h140, 0, 0, dflt(32'h140), 2, wop(32'h80, 32'h12345678), rop(32'h140));
    vecs[8]  = mk(0, 32'h80,  0, 0, 32'h12345678, 1, rop(32'h80), rop(0));
    vecs[9]  = mk(1, 32'h44,  32'h11110000, 0, 32'h11110000, 0, rop(0), rop(0));
    vecs[10] = mk(1, 32'h84,  32'h22220000, 0, 32'h22220000, 0, rop(0), rop(0));
    vecs[11] = mk(1, 32'hC4,  32'h33330000, 0, 32'h33330000, 0, rop(0), rop(0));
    vecs[12] = mk(1, 32'h104, 32'h44440000, 0, 32'h44440000, 0, rop(0), rop(0));
    vecs[13] = mk(1, 32'h84,  32'h5555AAAA, 1, 32'h5555AAAA, 0, rop(0), rop(0));
    vecs[14] = mk(0, 32'h84,  0, 1, 32'h5555AAAA, 0, rop(0), rop(0));

    mem[32'h40] = 32'hDEADBEEF;
    reset = 1'b1; req_valid = 1'b0; rd_wr = 1'b0; address = '0; write_data = '0;
    mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_hit_miss", hit_miss, 0);
    check("rst_read_data", read_data, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check_stats();
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      if (v.nmem > 0) exp_mem_q.push_back(v.op0);
      if (v.nmem > 1) exp_mem_q.push_back(v.op1);
      exp_resp_q.push_back('{hit: v.hit, data: v.data});
      send_req(v.wr, v.addr, v.wdata);
      wait_resp($sformatf("resp_timeout_vec%0d", i), cyc);
      if (v.hit) check("hit_latency", cyc, 2);
      check("memops_done", exp_mem_q.size(), 0);
    end
    check_stats();

    // Dirty victim 0x44 in set 1 with the memory port stalled.
    mem_req_ready = 1'b0;
    exp_mem_q.push_back(wop(32'h44, 32'h11110000));
    exp_mem_q.push_back(rop(32'h144));
    exp_resp_q.push_back('{hit: 1'b0, data: dflt(32'h144)});
    send_req(0, 32'h144, 0);
    k = 0;
    while (!mem_req_valid && k < 20) begin @(negedge clk); k++; end
    if (!mem_req_valid) fail_event("wb_start_timeout");
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", mem_req_valid, 1);
      check("stall_we", mem_we, 1);
      check("stall_addr", mem_addr, 32'h44);
      check("stall_wdata", mem_wdata, 32'h11110000);
      check("stall_req_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    wait_resp("resp_timeout_stall", cyc);
    check("memops_done_stall", exp_mem_q.size(), 0);
    check_stats();

    // Reset while waiting for refill data; the late mem_rvalid must be ignored.
    rd_lat = 8;
    exp_mem_q.push_back(rop(32'h48));
    send_req(0, 32'h48, 0);
    k = 0;
    while (exp_mem_q.size() != 0 && k < 20) begin @(posedge clk); k++; end
    if (exp_mem_q.size() != 0) begin
      fail_event("refill_req_timeout");
      exp_mem_q.delete();
    end
    #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_mem_req_valid", mem_req_valid, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    tb_hits = 0; tb_misses = 0; tb_wbs = 0;
    check_stats();
    repeat (12) @(posedge clk);
    #1;
    rd_lat = 1;
    exp_mem_q.push_back(rop(32'h40));
    exp_resp_q.push_back('{hit: 1'b0, data: 32'hDEADBEEF});
    send_req(0, 32'h40, 0);
    wait_resp("resp_timeout_after_reset", cyc);
    check("memops_done_after_reset", exp_mem_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
